address_sequencer: RTL and testbench
====================================

Name: address_sequencer

Overview:
- Parametrised successor to the fixed IP/MAC loader for the Ethernet-in-fabric core.
- Emits the 10-byte configuration stream on address_set: IP bytes LSB first, then MAC bytes LSB first. Each byte is {1'b1, data} for one cycle; the bus idles at 9'h000.
- Final octet of both IP and MAC is taken from host_id.
- Adds: initial delay, inter-byte gap, explicit reload, automatic reload when host_id changes and stays stable, busy/done status, completed-sequence counter.

Parameters:
- IP_NET, 32'h80038010, base IP; bits [7:0] ignored, replaced by host_id.
- MAC, 48'h125555000135, base MAC; bits [7:0] ignored, replaced by host_id.
- INIT_DLY, 2, cycles from reset release to first byte; legal range 1..255.
- GAP, 0, idle cycles (address_set = 0) inserted between consecutive bytes; legal range 0..255.
- STABLE_CYC, 16, consecutive cycles host_id must differ from the loaded value and stay constant before an auto reload; legal range 1..65535.
- AUTO_RELOAD, 1, 1 enables host-change reload; 0 disables it.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- host_id  input  8  final IP/MAC octet, e.g. from DIP switch; treated as quasi-static.
- reload  input  1  single-cycle request to resend the sequence.
- address_set  output  9  bit 8 = byte strobe, bits [7:0] = byte.
- busy  output  1  high from the first cycle of INIT/SEND until the done cycle.
- done  output  1  one-cycle pulse, in the cycle after the last byte.
- seq_count  output  8  count of completed sequences; wraps 255 -> 0.

Behaviour:
- Reset, asynchronous: address_set = 0, busy = 1, done = 0, seq_count = 0; state = INIT; pending = 0; stable counter = 0.
- INIT:
  - Count INIT_DLY cycles after rst_n deasserts.
  - Then snapshot host_id, IP and MAC into shadow registers and go to SEND with idx = 0.
- SEND:
  - Drive registered address_set = {1, byte[idx]}.
  - Byte order by idx: 0 host_id, 1 IP[15:8], 2 IP[23:16], 3 IP[31:24], 4 host_id, 5 MAC[15:8], 6 MAC[23:16], 7 MAC[31:24], 8 MAC[39:32], 9 MAC[47:40].
  - If idx = 9: go to DONE. Otherwise go to GAP if GAP > 0, or stay in SEND with idx + 1 if GAP = 0.
- GAP: address_set = 0 for exactly GAP cycles, then SEND with idx + 1.
- DONE:
  - One cycle: address_set = 0, done = 1, busy = 1, seq_count + 1.
  - Go to IDLE, or to START if pending is set.
- IDLE: busy = 0, address_set = 0.
  - reload = 1 -> START.
  - Auto trigger (below) -> START.
- START: one cycle; snapshot shadows, clear pending and the stable counter, go to SEND with idx = 0, busy = 1.
- Latency: reload seen in IDLE at cycle N gives the first strobe at N+2. Sequence duration is 10 + 9*GAP strobe/gap cycles, plus the DONE cycle.
- Auto trigger (AUTO_RELOAD = 1, IDLE only):
  - Stable counter increments while host_id != shadow host and host_id equals its previous-cycle value.
  - Any host_id change clears the counter.
  - Counter reaching STABLE_CYC triggers START.
- Mid-sequence inputs:
  - host_id changes during busy do not alter bytes in flight (shadow copy). They are evaluated once back in IDLE.
  - reload while busy (INIT, SEND, GAP or DONE) sets pending; exactly one extra sequence follows, and multiple requests merge.
  - reload coincident with an auto trigger -> one sequence only.
- rst_n asserted mid-sequence: outputs clear immediately. The partial sequence is abandoned and not counted; a full sequence restarts after INIT_DLY.
- seq_count is 8-bit modulo; no saturation.

Optional Feature:
- Macro ADDRESS_SEQUENCER_RUNTIME_EN.
- Defined:
  - Adds input ports ip_in[31:0] and mac_in[47:0].
  - They are snapshotted at INIT exit and START in place of IP_NET/MAC; bits [7:0] are still replaced by host_id.
  - A change of ip_in or mac_in while IDLE counts as a change for the auto-trigger stability logic, with the same STABLE_CYC rule.
- Undefined: ports absent; parameters only; logic identical otherwise.

Test Plan:
- Power-up, GAP = 0, INIT_DLY = 2, host_id = 8'h2A, release rst_n.
  - Expect address_set: 0,0, then 12A,180,103,180,12A,101,100,155,155,112.
  - Then done pulse; seq_count = 1; busy falls the cycle after done.
- GAP = 3:
  - Expect strobes 4 cycles apart; address_set = 0 in the 3 cycles between strobes.
  - Total 37 cycles from first strobe to last.
- host_id 2A -> 2B in IDLE, STABLE_CYC = 16: new sequence starts with first strobe = 12B.
  - Toggling 2B/2A every 5 cycles instead -> no sequence.
- reload pulsed at byte idx 4 of a running sequence, and again at idx 6:
  - Exactly one extra sequence follows back-to-back (DONE -> START -> SEND).
  - seq_count increments by 2 in total.
- rst_n low for 1 cycle at idx 7: address_set = 0 immediately and seq_count = 0; a full 10-byte sequence follows after INIT_DLY.
- seq_count wrap: 256 reload-driven sequences -> seq_count returns to 0.
  - With ADDRESS_SEQUENCER_RUNTIME_EN: ip_in = C0A80703, host_id = 05 -> IP bytes 105,107,1A8,1C0.

Source files
------------

// File: rtl/address_sequencer.sv
// address_sequencer: IP/MAC config byte streamer with reload/auto-reload; `define ADDRESS_SEQUENCER_RUNTIME_EN adds ip_in/mac_in
module address_sequencer #(
  parameter logic [31:0] IP_NET = 32'h80038010,
  parameter logic [47:0] MAC = 48'h125555000135,
  parameter int INIT_DLY = 2,
  parameter int GAP = 0,
  parameter int STABLE_CYC = 16,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input logic clk,
  input logic rst_n,
  input logic [7:0] host_id,
  input logic reload,
`ifdef ADDRESS_SEQUENCER_RUNTIME_EN
  input logic [31:0] ip_in,
  input logic [47:0] mac_in,
`endif
  output logic [8:0] address_set,
  output logic busy,
  output logic done,
  output logic [7:0] seq_count
);
  typedef enum logic [2:0] {S_INIT, S_SEND, S_GAP, S_DONE, S_IDLE, S_START} state_t;
  state_t state, state_n;
  logic [3:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic [15:0] stab, stab_n;
  logic pending, pending_n, snap, stab_inc;
  logic [87:0] cfg, sh, prev;
  logic [79:0] seq_v;
`ifdef ADDRESS_SEQUENCER_RUNTIME_EN
  assign cfg = {mac_in, ip_in, host_id};
`else
  assign cfg = {MAC, IP_NET, host_id};
`endif
  // byte k of the stream lives at seq_v[8k +: 8]; the shadow low octets are replaced by host_id
  assign seq_v = {sh[87:48], sh[7:0], sh[39:16], sh[7:0]};
  assign stab_inc = AUTO_RELOAD && state == S_IDLE && cfg != sh && cfg == prev;
  assign address_set = state == S_SEND ? {1'b1, seq_v[{idx, 3'b000} +: 8]} : 9'h000;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  // State, counters, shadow copy of the loaded configuration and completed-sequence count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      idx <= '0;
      cnt <= '0;
      stab <= '0;
      pending <= 1'b0;
      sh <= '0;
      prev <= '0;
      seq_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      stab <= stab_n;
      pending <= pending_n;
      sh <= snap ? cfg : sh;
      prev <= cfg;
      seq_count <= seq_count + {7'd0, done};
    end
  end
  // Next-state logic; reloads arriving while busy merge into a single pending request
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    stab_n = stab_inc ? stab + 16'd1 : 16'd0;
    pending_n = pending | (reload & busy & state != S_START);
    snap = 1'b0;
    case (state)
      S_INIT: begin
        cnt_n = cnt == 8'(INIT_DLY - 1) ? 8'd0 : cnt + 8'd1;
        snap = cnt == 8'(INIT_DLY - 1);
        state_n = snap ? S_SEND : S_INIT;
        idx_n = 4'd0;
      end
      S_SEND: begin
        state_n = idx == 4'd9 ? S_DONE : GAP > 0 ? S_GAP : S_SEND;
        idx_n = idx != 4'd9 && GAP == 0 ? idx + 4'd1 : idx;
        cnt_n = 8'd0;
      end
      S_GAP: begin
        state_n = cnt == 8'(GAP - 1) ? S_SEND : S_GAP;
        idx_n = cnt == 8'(GAP - 1) ? idx + 4'd1 : idx;
        cnt_n = cnt + 8'd1;
      end
      S_DONE: state_n = pending | reload ? S_START : S_IDLE;
      S_IDLE: state_n = reload || (stab_inc && stab == 16'(STABLE_CYC - 1)) ? S_START : S_IDLE;
      S_START: begin
        snap = 1'b1;
        pending_n = 1'b0;
        stab_n = 16'd0;
        idx_n = 4'd0;
        cnt_n = 8'd0;
        state_n = S_SEND;
      end
      default: state_n = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_address_sequencer.sv
// tb_address_sequencer: randomized reload/host stimulus checked against a byte-stream reference model
`timescale 1ns/1ps
module tb_address_sequencer;
  localparam logic [31:0] IP_NET = 32'h80038010;
  localparam logic [47:0] MAC = 48'h125555000135;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3_n = 1'b0;
  logic reload = 1'b0;
  logic reload3 = 1'b0;
  logic [7:0] host_id = 8'h2A;
  logic [31:0] ip_cur = IP_NET;
  logic [47:0] mac_cur = MAC;
  logic [8:0] a0, a3;
  logic busy0, busy3, done0, done3;
  logic [7:0] cnt0, cnt3;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] h;
  logic [9:0] p;
  int n, nseq, t0, strobes;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  address_sequencer #(.IP_NET(IP_NET), .MAC(MAC), .INIT_DLY(2), .GAP(0), .STABLE_CYC(16), .AUTO_RELOAD(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .host_id(host_id), .reload(reload),
`ifdef ADDRESS_SEQUENCER_RUNTIME_EN
    .ip_in(ip_cur), .mac_in(mac_cur),
`endif
    .address_set(a0), .busy(busy0), .done(done0), .seq_count(cnt0));

  address_sequencer #(.IP_NET(IP_NET), .MAC(MAC), .INIT_DLY(2), .GAP(3), .STABLE_CYC(16), .AUTO_RELOAD(1'b1)) u_gap (
    .clk(clk), .rst_n(rst3_n), .host_id(host_id), .reload(reload3),
`ifdef ADDRESS_SEQUENCER_RUNTIME_EN
    .ip_in(ip_cur), .mac_in(mac_cur),
`endif
    .address_set(a3), .busy(busy3), .done(done3), .seq_count(cnt3));

  function automatic logic [7:0] exp_byte(input logic [7:0] hh, input int i);
    logic [7:0] b [10];
    b = '{hh, ip_cur[15:8], ip_cur[23:16], ip_cur[31:24], hh,
          mac_cur[15:8], mac_cur[23:16], mac_cur[31:24], mac_cur[39:32], mac_cur[47:40]};
    return b[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_stream(input bit s, input logic [7:0] hh, input int gap, input logic [9:0] pulse);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("byte%0d", i), 32'(s ? a3 : a0), {23'd0, 1'b1, exp_byte(hh, i)});
      if (pulse[i]) reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      for (int g = 0; g < gap && i < 9; g++) begin
        chk("gap", 32'(s ? a3 : a0), 32'd0);
        @(negedge clk);
      end
    end
    chk("done", 32'(s ? {busy3, done3, a3} : {busy0, done0, a0}), 32'h600);
  endtask

  task automatic wait_strobe(input int lim, output int k);
    k = 0;
    while (a0[8] !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic idle_tail;
    @(negedge clk);
    chk("idle", 32'({busy0, done0, a0}), 32'd0);
    chk("count", 32'(cnt0), 32'(exp_cnt));
  endtask

  task automatic reload_seq(input logic [7:0] hh, input logic [9:0] pulse);
    chk("pre_idle", 32'(busy0), 32'd0);
    host_id = hh;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("start", 32'({busy0, a0}), 32'h200);
    @(negedge clk);
    check_stream(1'b0, hh, 0, pulse);
    exp_cnt++;
    if (pulse != 10'd0) begin
      @(negedge clk);
      chk("restart", 32'({busy0, a0}), 32'h200);
      @(negedge clk);
      check_stream(1'b0, hh, 0, 10'd0);
      exp_cnt++;
    end
    idle_tail();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset", 32'({busy0, done0, cnt0, a0}), 32'h40000);
    chk("g_reset", 32'({busy3, a3}), 32'h200);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("init0", 32'(a0), 32'd0);
    @(negedge clk);
    chk("init1", 32'(a0), 32'd0);
    @(negedge clk);
    check_stream(1'b0, 8'h2A, 0, 10'd0);
    exp_cnt++;
    idle_tail();
    // host change held stable in IDLE triggers an automatic reload
    host_id = 8'h2B;
    wait_strobe(40, n);
    chk("auto_lat", 32'(n >= 16 && n <= 20), 32'd1);
    if (a0[8]) begin
      check_stream(1'b0, 8'h2B, 0, 10'd0);
      exp_cnt++;
      idle_tail();
    end
    // host toggling faster than the stability window must not reload
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      host_id = i % 2 == 0 ? 8'h2A : 8'h2B;
      repeat (5) begin
        @(negedge clk);
        strobes += a0[8] ? 1 : 0;
      end
    end
    chk("toggle_quiet", 32'(strobes), 32'd0);
    // two reloads mid-sequence merge into exactly one extra sequence
    reload_seq(8'h2B, 10'b0001010000);
    // reset mid-sequence abandons it; full sequence restarts
    host_id = 8'h2B;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("pre_rst_byte7", 32'(a0), {23'd0, 1'b1, exp_byte(8'h2B, 7)});
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({busy0, done0, cnt0, a0}), 32'h40000);
    exp_cnt = 8'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rinit0", 32'(a0), 32'd0);
    @(negedge clk);
    chk("rinit1", 32'(a0), 32'd0);
    @(negedge clk);
    check_stream(1'b0, 8'h2B, 0, 10'd0);
    exp_cnt++;
    idle_tail();
    // random hosts and random mid-sequence reloads until seq_count wraps to 0
    nseq = 1;
    while (nseq < 256) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      h = 8'($urandom);
      p = ($urandom_range(0, 3) == 0 && nseq < 255) ? 10'(1 << $urandom_range(0, 9)) : 10'd0;
      reload_seq(h, p);
      nseq += p != 10'd0 ? 2 : 1;
    end
    chk("wrap", 32'(cnt0), 32'd0);
    // GAP = 3 instance: strobes 4 cycles apart, 37 cycles first to last strobe
    @(posedge clk);
    #1 rst3_n = 1'b1;
    @(negedge clk);
    chk("g_init0", 32'(a3), 32'd0);
    @(negedge clk);
    chk("g_init1", 32'(a3), 32'd0);
    @(negedge clk);
    t0 = cyc;
    check_stream(1'b1, host_id, 3, 10'd0);
    chk("g_span", 32'(cyc - t0), 32'd37);
    @(negedge clk);
    chk("g_count", 32'({busy3, cnt3}), 32'd1);
`ifdef ADDRESS_SEQUENCER_RUNTIME_EN
    ip_cur = 32'hC0A80703;
    reload_seq(8'h05, 10'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
